cg_mem_copy_engine: RTL and testbench

//  Initiator for CG_memory_interface: copies LEN words from src_base to dst_base on one memory port.

---
 rtl/cg_mem_pkg.sv | 18 +
 rtl/cg_sync_fifo.sv | 60 ++++++
 rtl/cg_mem_copy_engine.sv | 151 +++++++++++++++
 tb/tb_cg_mem_copy_engine.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cg_mem_pkg.sv
// Shared types and sizing helpers for the CG memory copy engine.
package cg_mem_pkg;

    typedef enum logic [1:0] {
        CPY_IDLE,
        CPY_RUN,
        CPY_FINISH
    } cpy_state_t;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cg_sync_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide.
module cg_sync_fifo
    import cg_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        pop,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PW = fifo_ptr_w(FIFO_DEPTH);
    localparam int CW = fifo_cnt_w(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/cg_mem_copy_engine.sv
// Copies LEN words src->dst over one CG memory port, with
// read credits bounded by the depth of the read-data FIFO.
module cg_mem_copy_engine
    import cg_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_araddr,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rready,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_wvalid,
    input  logic                  mem_wready
);

    localparam int CW = fifo_cnt_w(FIFO_DEPTH);
    localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

    cpy_state_t state;
    cpy_state_t state_nxt;

    logic [ADDR_WIDTH-1:0] src_r;
    logic [ADDR_WIDTH-1:0] dst_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  rd_issued;
    logic [LEN_WIDTH-1:0]  wr_done;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           in_flight;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  running;
    logic                  accept;
    logic                  ar_hs;
    logic                  rsp;
    logic                  w_hs;
    logic                  last_wr;

    assign running   = (state == CPY_RUN);
    assign accept    = (state == CPY_IDLE) && start;
    assign in_flight = {1'b0, fifo_count} + {1'b0, outstanding};

    assign mem_arvalid = running && (rd_issued < len_r)
                         && (in_flight < CREDITS);
    assign ar_hs       = mem_arvalid && mem_arready;
    // Stray responses are dropped rather than corrupting the FIFO
    assign rsp         = mem_rvalid && running
                         && (outstanding != '0) && !fifo_full;
    assign mem_wvalid  = running && !fifo_empty;
    assign mem_wen     = mem_wvalid;
    assign w_hs        = mem_wvalid && mem_wready;
    assign last_wr     = w_hs && (wr_done == len_r - LEN_WIDTH'(1));

    assign mem_araddr = mem_arvalid ?
                        src_r + ADDR_WIDTH'(rd_issued) : '0;
    assign mem_waddr  = mem_wvalid ?
                        dst_r + ADDR_WIDTH'(wr_done) : '0;
    assign mem_wdata  = mem_wvalid ? fifo_head : '0;
    assign mem_rready = running;
    assign busy       = running;
    assign done       = (state == CPY_FINISH);

    cg_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (rsp),
        .wdata(mem_rdata),
        .pop  (w_hs),
        .rdata(fifo_head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CPY_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CPY_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? CPY_FINISH : CPY_RUN;
                end
            end
            CPY_RUN: begin
                if (last_wr) begin
                    state_nxt = CPY_FINISH;
                end
            end
            CPY_FINISH: state_nxt = CPY_IDLE;
            default:    state_nxt = CPY_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_r       <= '0;
            dst_r       <= '0;
            len_r       <= '0;
            rd_issued   <= '0;
            wr_done     <= '0;
            outstanding <= '0;
        end else if (accept) begin
            src_r       <= src_base;
            dst_r       <= dst_base;
            len_r       <= len;
            rd_issued   <= '0;
            wr_done     <= '0;
            outstanding <= '0;
        end else begin
            if (ar_hs) begin
                rd_issued <= rd_issued + LEN_WIDTH'(1);
            end
            if (w_hs) begin
                wr_done <= wr_done + LEN_WIDTH'(1);
            end
            if (ar_hs && !rsp) begin
                outstanding <= outstanding + CW'(1);
            end else if (rsp && !ar_hs) begin
                outstanding <= outstanding - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cg_mem_copy_engine.sv
// Scoreboard bench: memory model, random handshakes, reference copy model.
module tb_cg_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_base = '0;
    logic [31:0] dst_base = '0;
    logic [15:0] len = '0;
    logic        busy;
    logic        done;
    logic [31:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        mem_wvalid;
    logic        mem_wready = 1'b1;

    always #5 clk = ~clk;

    cg_mem_copy_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .mem_araddr (mem_araddr),
        .mem_arvalid(mem_arvalid),
        .mem_arready(mem_arready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rready (mem_rready),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ar_cnt = 0;
    int w_cnt = 0;
    bit ar_rand = 0;
    bit w_rand = 0;
    bit w_hold = 0;
    bit loaded = 0;

    logic [31:0] mem  [1024];
    logic [31:0] init [1024];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];

    // Memory model: accepts reads, returns data one cycle later
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init[i];
            loaded <= 1'b1;
        end else if (!rst_n) begin
            mem_rvalid <= 1'b0;
        end else begin
            mem_rvalid <= mem_arvalid && mem_arready;
            if (mem_arvalid && mem_arready) begin
                mem_rdata <= mem[mem_araddr[9:0]];
                ar_cnt    <= ar_cnt + 1;
            end
            if (mem_wvalid && mem_wready) begin
                mem[mem_waddr[9:0]] <= mem_wdata;
                w_cnt               <= w_cnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            mem_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_wready  = w_hold ? 1'b0 :
                          (w_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    endtask

    task automatic monitor();
        logic [31:0] ea;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (rst_n && mem_rvalid)
                chk("rvalid_while_not_ready", 64'(mem_rready), 64'(1));
            if (rst_n && mem_wvalid && mem_wready) begin
                chk("wen_eq_wvalid", 64'(mem_wen), 64'(1));
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h expected none",
                             mem_waddr);
                end else begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    chk("write_addr", 64'(mem_waddr), 64'(ea));
                    chk("write_data", 64'(mem_wdata), 64'(ed));
                end
            end
        end
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d,
                              input logic [15:0] l);
        logic [9:0] si;
        @(posedge clk);
        #1;
        src_base = s;
        dst_base = d;
        len      = l;
        start    = 1'b1;
        for (int i = 0; i < int'(l); i++) begin
            si = 10'(s + 32'(i));
            exp_addr.push_back(d + 32'(i));
            exp_data.push_back(init[si]);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int l, input bit timing);
        int busy_n = 0;
        int first_busy = 0;
        int done_at = 0;
        for (int k = 1; k <= 3000 && done_at == 0; k++) begin
            @(negedge clk);
            if (busy) begin
                busy_n++;
                if (first_busy == 0) first_busy = k;
            end
            if (done) done_at = k;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("done_seen", 64'(done_at != 0), 64'(1));
        if (timing) begin
            chk("done_cycle", 64'(done_at), 64'((l == 0) ? 1 : l + 3));
            chk("busy_cycles", 64'(busy_n), 64'((l == 0) ? 0 : l + 2));
            chk("busy_first", 64'(first_busy), 64'((l == 0) ? 0 : 1));
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("busy_after_done", 64'(busy), 64'(0));
    endtask

    task automatic verify_mem(input logic [31:0] s, input logic [31:0] d,
                              input int l);
        logic [9:0] si;
        logic [9:0] di;
        for (int i = 0; i < l; i++) begin
            si = 10'(s + 32'(i));
            di = 10'(d + 32'(i));
            chk("mem_copy", 64'(mem[di]), 64'(init[si]));
        end
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_busy"}, 64'(busy), 64'(0));
        chk({nm, "_done"}, 64'(done), 64'(0));
        chk({nm, "_arvalid"}, 64'(mem_arvalid), 64'(0));
        chk({nm, "_wvalid"}, 64'(mem_wvalid), 64'(0));
        chk({nm, "_wen"}, 64'(mem_wen), 64'(0));
        chk({nm, "_rready"}, 64'(mem_rready), 64'(0));
        chk({nm, "_araddr"}, 64'(mem_araddr), 64'(0));
        chk({nm, "_waddr"}, 64'(mem_waddr), 64'(0));
        chk({nm, "_wdata"}, 64'(mem_wdata), 64'(0));
    endtask

    initial begin
        int a0;
        int w0;
        int d0;
        int n;
        logic [31:0] s;
        logic [31:0] d;
        logic [15:0] l;

        for (int i = 0; i < 1024; i++) init[i] = $urandom;
        for (int i = 0; i < 4; i++) init[16 + i] = 32'hA0 + 32'(i);

        fork
            monitor();
            ready_driver();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        start_copy(32'h10, 32'h80, 16'd4);
        wait_done(4, 1'b1);
        verify_mem(32'h10, 32'h80, 4);

        a0 = ar_cnt;
        w0 = w_cnt;
        start_copy(32'h50, 32'h90, 16'd0);
        wait_done(0, 1'b1);
        chk("len0_reads", 64'(ar_cnt - a0), 64'(0));
        chk("len0_writes", 64'(w_cnt - w0), 64'(0));

        w_hold = 1'b1;
        a0 = ar_cnt;
        start_copy(32'h120, 32'h300, 16'd16);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stall_reads", 64'(ar_cnt - a0), 64'(4));
        chk("stall_arvalid", 64'(mem_arvalid), 64'(0));
        w_hold = 1'b0;
        wait_done(16, 1'b0);
        verify_mem(32'h120, 32'h300, 16);

        ar_rand = 1'b1;
        w_rand  = 1'b1;
        repeat (15) begin
            s = 32'h100 + 32'($urandom_range(0, 'hE0));
            d = 32'h200 + 32'($urandom_range(0, 'h1C0));
            l = 16'($urandom_range(1, 30));
            start_copy(s, d, l);
            wait_done(int'(l), 1'b0);
            verify_mem(s, d, int'(l));
        end
        ar_rand = 1'b0;
        w_rand  = 1'b0;
        repeat (2) @(posedge clk);

        d0 = done_cnt;
        w0 = w_cnt;
        start_copy(32'h140, 32'h240, 16'd8);
        n = 0;
        while ((w_cnt - w0) < 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reset_wait_writes", 64'(w_cnt - w0), 64'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        exp_addr.delete();
        exp_data.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("no_done_after_abort", 64'(done_cnt - d0), 64'(0));
        start_copy(32'h140, 32'h240, 16'd8);
        wait_done(8, 1'b1);
        verify_mem(32'h140, 32'h240, 8);

        d0 = done_cnt;
        start_copy(32'h180, 32'h280, 16'd10);
        @(posedge clk);
        #1;
        start    = 1'b1;
        src_base = 32'h1A0;
        dst_base = 32'h380;
        len      = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(10, 1'b0);
        verify_mem(32'h180, 32'h280, 10);
        repeat (5) @(posedge clk);
        chk("single_done_when_restarted", 64'(done_cnt - d0), 64'(1));

        chk("scoreboard_empty", 64'(exp_addr.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
